usb_lane_deframer: RTL
======================

# usb_lane_deframer

Receive-side deframer for one 4-lane nibble link of the USB LVDS front end. It takes the 4-bit word produced by a lane group's IBUFDS pairs, hunts for the sync byte and assembles nibbles into bytes. It then parses the length and payload fields, checks the frame checksum, and streams payload bytes to the 200 MHz fabric with per-frame good/bad status. It is the receiving end of the nibble framing driven onto the `usb_rxd*` output lane groups.

## Interface
Parameters:
- `SYNC_HI`, 4'hA: first sync nibble.
- `SYNC_LO`, 4'h5: second sync nibble.
- `ERR_W`, 16: width of the saturating error counter.

Ports:
- `clk`  in  1  200 MHz fabric clock (`clk_out_200`).
- `rst`  in  1  reset, asynchronous, active-high.
- `lane_d`  in  4  lane-group nibble from IBUFDS; one nibble per `clk`, already in the `clk` domain.
- `m_data`  out  8  payload byte.
- `m_valid`  out  1  one-cycle strobe; `m_data` is valid in that cycle.
- `m_last`  out  1  asserted with `m_valid` on the final payload byte.
- `frm_ok`  out  1  one-cycle pulse: frame complete and checksum good.
- `frm_err`  out  1  one-cycle pulse: frame rejected.
- `err_cnt`  out  ERR_W  count of rejected frames; saturates at all-ones.
- `busy`  out  1  high whenever the FSM is not in HUNT.

## Operation
- Input register: `lane_q <= lane_d` every cycle. The FSM consumes `lane_q` only.
- Bytes are sent high nibble first. The `phase` bit selects the nibble: 0 means the high nibble is latched into `hi_q`; 1 means the byte `{hi_q, lane_q}` is complete.
- Frame format: sync byte `{SYNC_HI, SYNC_LO}`, then `LEN` (1..255), then `LEN` payload bytes, then `CHK`.
- `CHK` is chosen so that `LEN` + payload + `CHK` ≡ 0 mod 256.
- Running sum `sum[7:0]` is computed with mod-256 wraparound and no carry out.

FSM states:
- **HUNT**
  - `prev` holds the last `lane_q`.
  - When `prev == SYNC_HI` and `lane_q == SYNC_LO`: go to LEN, `phase = 0`.
  - `prev` is cleared to 0 on entry to HUNT, so a sync nibble pair is only recognised when both nibbles arrive in HUNT.
- **LEN**
  - On byte complete: `rem <= byte`, `sum <= byte`.
  - If `byte == 0`: pulse `frm_err`, increment `err_cnt`, go to HUNT.
  - Otherwise go to DATA.
- **DATA**
  - On each complete byte: `m_data <= byte`, `m_valid <= 1`, `sum <= sum + byte`, `rem <= rem - 1`.
  - When `rem == 1`: assert `m_last` and go to CHK.
  - Sync patterns inside the payload are ignored.
- **CHK**
  - On byte complete: if `sum + byte == 0`, pulse `frm_ok`; otherwise pulse `frm_err` and increment `err_cnt`.
  - Go to HUNT.

Boundary conditions:
- Back-to-back frames: sync may start on the nibble immediately after the `CHK` low nibble.
- `err_cnt` holds at `{ERR_W{1'b1}}` once reached.
- `m_valid`, `m_last`, `frm_ok` and `frm_err` are single-cycle pulses.
- `frm_ok` and `frm_err` are never high together.
- Reset mid-frame: everything clears and no status pulse is issued. A partial frame is therefore reported only by the absence of `frm_ok`.

## Timing
- Reset values:
  - `m_data` = 0, `m_valid` = `m_last` = `frm_ok` = `frm_err` = `busy` = 0, `err_cnt` = 0.
  - State HUNT, `phase` = 0, `prev` = 0.
- Latency: the low nibble of a byte is on `lane_d` at edge k. The matching `m_valid` (or status pulse) is high in the cycle after edge k+1, i.e. 2 clocks.
- Payload byte rate is one byte per 2 clocks. `m_valid` is never high on two consecutive cycles.
- `frm_ok`/`frm_err` fire 2 cycles after the `m_last` strobe (checksum enabled).
- There is no backpressure. The consumer must accept every `m_valid`.

## Configuration
- `USB_LANE_DEFRAMER_CHK_EN` defined: the `CHK` byte is expected and checked as described above.
- Not defined:
  - No CHK state and no `sum` logic.
  - `frm_ok` pulses in the same cycle as `m_last`, and the FSM returns to HUNT.
  - `frm_err` fires only for `LEN == 0`.

## Structure
- Shared package `usb_lane_pkg` holds:
  - the state enum (HUNT/LEN/DATA/CHK);
  - `SYNC_HI`/`SYNC_LO` defaults;
  - the `USB_LANE_W = 4` constant.
  These are shared with the lane transmitter.
- One sub-module, `usb_nib2byte`: input register, `phase`, `hi_q`, and outputs `byte`/`byte_stb`. The FSM and counters live in the top.

## Test plan
- Good frame: nibbles A,5,0,3,1,1,2,2,3,3,9,7 → `m_data` 11,22,33, with `m_last` on 33, then `frm_ok` 2 cycles later; `err_cnt` stays 0.
- Bad checksum: same frame with final nibbles 9,8 → bytes 11,22,33 are still streamed, then `frm_err` pulses and `err_cnt` = 1.
- Zero length: A,5,0,0 → `frm_err` and no `m_valid`; the next valid frame is received normally.
- Sync inside payload: `LEN` = 2, payload A5 01, `CHK` 0x58 → 2 bytes A5,01 then `frm_ok`; no resync occurs.
- Reset mid-DATA after 1 byte, then a full good frame → no status pulse before the reset, and the new frame gives `frm_ok`.
- `ERR_W` = 2 with 5 zero-length frames → `err_cnt` = 1,2,3,3,3.

Source files
------------

// File: rtl/usb_lane_pkg.sv
// Shared lane-link definitions: deframer state encoding, sync nibbles, lane width.
package usb_lane_pkg;

  localparam int USB_LANE_W = 4;

  localparam logic [USB_LANE_W-1:0] SYNC_HI_DEF = 4'hA;
  localparam logic [USB_LANE_W-1:0] SYNC_LO_DEF = 4'h5;

  typedef enum logic [1:0] {
    HUNT = 2'd0,
    LEN  = 2'd1,
    DATA = 2'd2,
    CHK  = 2'd3
  } lane_state_e;

endpackage

// File: rtl/usb_nib2byte.sv
// Registers the lane nibble and pairs nibbles into bytes, high nibble first.
// align forces the next nibble to be treated as a high nibble.
module usb_nib2byte
  import usb_lane_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic [USB_LANE_W-1:0] lane_d,
  input  logic                  align,
  output logic [USB_LANE_W-1:0] lane_q,
  output logic [7:0]            byte_dat,
  output logic                  byte_stb
);

  logic                  phase;
  logic [USB_LANE_W-1:0] hi_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lane_q <= '0;
      phase  <= 1'b0;
      hi_q   <= '0;
    end else begin
      lane_q <= lane_d;
      phase  <= align ? 1'b0 : ~phase;
      if (!phase) hi_q <= lane_q;
    end
  end

  assign byte_dat = {hi_q, lane_q};
  assign byte_stb = phase;

endmodule

// File: rtl/usb_lane_deframer.sv
// Nibble-link receive deframer: sync hunt, LEN/payload parse, payload streaming, frame status.
// Define USB_LANE_DEFRAMER_CHK_EN to expect and verify the trailing mod-256 CHK byte.
module usb_lane_deframer
  import usb_lane_pkg::*;
#(
  parameter logic [USB_LANE_W-1:0] SYNC_HI = SYNC_HI_DEF,
  parameter logic [USB_LANE_W-1:0] SYNC_LO = SYNC_LO_DEF,
  parameter int                    ERR_W   = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [USB_LANE_W-1:0] lane_d,
  output logic [7:0]            m_data,
  output logic                  m_valid,
  output logic                  m_last,
  output logic                  frm_ok,
  output logic                  frm_err,
  output logic [ERR_W-1:0]      err_cnt,
  output logic                  busy
);

  logic [USB_LANE_W-1:0] lane_q;
  logic [7:0]            byte_dat;
  logic                  byte_stb;
  logic                  align;

  lane_state_e           state, state_nxt;
  logic [USB_LANE_W-1:0] prev, prev_nxt;
  logic [7:0]            rem, rem_nxt;
  logic [7:0]            data_nxt;
  logic                  valid_nxt, last_nxt, ok_nxt, err_nxt;
`ifdef USB_LANE_DEFRAMER_CHK_EN
  logic [7:0]            sum, sum_nxt, chk_sum;
`endif

  usb_nib2byte u_nib2byte (
    .clk      (clk),
    .rst      (rst),
    .lane_d   (lane_d),
    .align    (align),
    .lane_q   (lane_q),
    .byte_dat (byte_dat),
    .byte_stb (byte_stb)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= HUNT;
      prev    <= '0;
      rem     <= '0;
      m_data  <= '0;
      m_valid <= 1'b0;
      m_last  <= 1'b0;
      frm_ok  <= 1'b0;
      frm_err <= 1'b0;
      err_cnt <= '0;
`ifdef USB_LANE_DEFRAMER_CHK_EN
      sum     <= '0;
`endif
    end else begin
      state   <= state_nxt;
      prev    <= prev_nxt;
      rem     <= rem_nxt;
      m_data  <= data_nxt;
      m_valid <= valid_nxt;
      m_last  <= last_nxt;
      frm_ok  <= ok_nxt;
      frm_err <= err_nxt;
      if (err_nxt && (err_cnt != {ERR_W{1'b1}})) err_cnt <= err_cnt + 1'b1;
`ifdef USB_LANE_DEFRAMER_CHK_EN
      sum     <= sum_nxt;
`endif
    end
  end

`ifdef USB_LANE_DEFRAMER_CHK_EN
  // 8-bit so the zero test sees the mod-256 sum, not the carry.
  assign chk_sum = sum + byte_dat;
`endif

  always_comb begin
    state_nxt = state;
    prev_nxt  = prev;
    rem_nxt   = rem;
    data_nxt  = m_data;
    valid_nxt = 1'b0;
    last_nxt  = 1'b0;
    ok_nxt    = 1'b0;
    err_nxt   = 1'b0;
    align     = 1'b0;
`ifdef USB_LANE_DEFRAMER_CHK_EN
    sum_nxt   = sum;
`endif
    case (state)
      HUNT: begin
        prev_nxt = lane_q;
        if (prev == SYNC_HI && lane_q == SYNC_LO) begin
          state_nxt = LEN;
          align     = 1'b1;
        end
      end
      LEN: begin
        if (byte_stb) begin
          rem_nxt = byte_dat;
`ifdef USB_LANE_DEFRAMER_CHK_EN
          sum_nxt = byte_dat;
`endif
          if (byte_dat == 8'd0) begin
            err_nxt   = 1'b1;
            state_nxt = HUNT;
            prev_nxt  = '0;
          end else begin
            state_nxt = DATA;
          end
        end
      end
      DATA: begin
        if (byte_stb) begin
          data_nxt  = byte_dat;
          valid_nxt = 1'b1;
          rem_nxt   = rem - 8'd1;
`ifdef USB_LANE_DEFRAMER_CHK_EN
          sum_nxt   = chk_sum;
`endif
          if (rem == 8'd1) begin
            last_nxt = 1'b1;
`ifdef USB_LANE_DEFRAMER_CHK_EN
            state_nxt = CHK;
`else
            ok_nxt    = 1'b1;
            state_nxt = HUNT;
            prev_nxt  = '0;
`endif
          end
        end
      end
`ifdef USB_LANE_DEFRAMER_CHK_EN
      CHK: begin
        if (byte_stb) begin
          if (chk_sum == 8'd0) ok_nxt = 1'b1;
          else                 err_nxt = 1'b1;
          state_nxt = HUNT;
          prev_nxt  = '0;
        end
      end
`endif
      default: begin
        state_nxt = HUNT;
        prev_nxt  = '0;
      end
    endcase
  end

  assign busy = (state != HUNT);

endmodule
